mfp_fft_bin_streamer: RTL and testbench

- Output-side companion to MFP_FFT. Captures one complete packed FFT frame (FFTL complex bins, FFTW bits per component) from the parallel result bus.
- Emits the captured frame one bin per handshake on a valid/ready stream, for downstream serial consumers such as peak search and descriptor build.
- Ping-pong double buffer: a new frame can be captured while the previous frame is still being streamed out.

---
 rtl/mfp_fft_bin_streamer.sv | 97 +++++++++
 tb/tb_mfp_fft_bin_streamer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_fft_bin_streamer.sv
// Ping-pong frame buffer: captures a packed FFT frame and streams it out one bin per handshake.
// Optional MFP_STREAM_BITREV_EN emits bins in bit-reversed index order.
module mfp_fft_bin_streamer #(
   parameter int unsigned FFTL = 16,
   parameter int unsigned FFTW = 8,
   parameter int unsigned IDXW = $clog2(FFTL)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FFTL*FFTW-1:0] in_re,
   input  logic [FFTL*FFTW-1:0] in_im,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FFTW-1:0]      out_re,
   output logic [FFTW-1:0]      out_im,
   output logic [IDXW-1:0]      out_idx,
   output logic                 out_last
);

   localparam int unsigned     BUSW     = FFTL * FFTW;
   localparam logic [IDXW-1:0] POS_LAST = IDXW'(FFTL - 1);

   logic [BUSW-1:0] bank_re [2];
   logic [BUSW-1:0] bank_im [2];
   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic            wr_bank;
   logic            rd_bank;
   logic [IDXW-1:0] pos;
   logic [IDXW-1:0] sel;
   logic            cap;
   logic            adv;
   logic            rel;

   // Emission order of bins within a frame.
   function automatic logic [IDXW-1:0] map_idx(input logic [IDXW-1:0] p);
      logic [IDXW-1:0] r;
`ifdef MFP_STREAM_BITREV_EN
      for (int i = 0; i < int'(IDXW); i++) r[i] = p[int'(IDXW) - 1 - i];
`else
      r = p;
`endif
      return r;
   endfunction

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign cap       = in_valid && in_ready;
   assign adv       = out_valid && out_ready;
   assign rel       = adv && (pos == POS_LAST);
   assign sel       = map_idx(pos);

   // Capture and release always target different banks, so both can apply in one cycle.
   always_comb begin
      full_nxt = full;
      if (cap) full_nxt[wr_bank] = 1'b1;
      if (rel) full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         pos     <= '0;
      end else begin
         full <= full_nxt;
         if (cap) wr_bank <= !wr_bank;
         if (adv) pos <= (pos == POS_LAST) ? '0 : pos + IDXW'(1);
         if (rel) rd_bank <= !rd_bank;
      end
   end

   // Frame storage carries no reset; contents are only observed once a bank is marked full.
   always_ff @(posedge clk) begin
      if (cap) begin
         bank_re[wr_bank] <= in_re;
         bank_im[wr_bank] <= in_im;
      end
   end

   always_comb begin
      out_re   = '0;
      out_im   = '0;
      out_idx  = '0;
      out_last = 1'b0;
      if (out_valid) begin
         out_re   = bank_re[rd_bank][int'(sel) * int'(FFTW) +: FFTW];
         out_im   = bank_im[rd_bank][int'(sel) * int'(FFTW) +: FFTW];
         out_idx  = sel;
         out_last = (pos == POS_LAST);
      end
   end

endmodule

// File: tb/tb_mfp_fft_bin_streamer.sv
// Self-checking bench for mfp_fft_bin_streamer against a frame-queue reference model.
module tb_mfp_fft_bin_streamer;

   localparam int unsigned FFTL = 16;
   localparam int unsigned FFTW = 8;
   localparam int unsigned IDXW = 4;
   localparam int unsigned BUSW = FFTL * FFTW;

   typedef logic [2*BUSW-1:0] frame_t;
   typedef struct packed {
      logic            rdy;
      logic            v;
      logic [IDXW-1:0] idx;
      logic [FFTW-1:0] re;
      logic [FFTW-1:0] im;
      logic            last;
   } exp_t;
   localparam int unsigned OBSW = $bits(exp_t);

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [BUSW-1:0] in_re;
   logic [BUSW-1:0] in_im;
   logic            out_valid;
   logic            out_ready;
   logic [FFTW-1:0] out_re;
   logic [FFTW-1:0] out_im;
   logic [IDXW-1:0] out_idx;
   logic            out_last;
   exp_t            obs;

   int     total;
   int     bad;
   frame_t mq[$];
   int     mpos;

   mfp_fft_bin_streamer #(.FFTL(FFTL), .FFTW(FFTW), .IDXW(IDXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_idx(out_idx), .out_last(out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {in_ready, out_valid, out_idx, out_re, out_im, out_last};

   // Emission position -> bin index.
   function automatic int map_exp(input int p);
      int r = 0;
`ifdef MFP_STREAM_BITREV_EN
      for (int i = 0; i < int'(IDXW); i++) r = r * 2 + ((p >> i) & 1);
`else
      r = p;
`endif
      return r;
   endfunction

   // Expected outputs: up to two frames queued in capture order, head frame streaming at mpos.
   function automatic exp_t model_out();
      exp_t   e;
      frame_t fr;
      int     b;
      e     = '0;
      e.rdy = (mq.size() < 2);
      e.v   = (mq.size() > 0);
      if (e.v) begin
         fr     = mq[0];
         b      = map_exp(mpos);
         e.idx  = IDXW'(b);
         e.re   = fr[b*FFTW +: FFTW];
         e.im   = fr[BUSW + b*FFTW +: FFTW];
         e.last = (mpos == FFTL - 1);
      end
      return e;
   endfunction

   // One clock with the given handshakes; advances the reference model alongside.
   task automatic step(input logic v, input logic r);
      frame_t f;
      bit     cap;
      bit     adv;
      in_valid  = v;
      out_ready = r;
      f   = {in_im, in_re};
      cap = v && (mq.size() < 2);
      adv = (mq.size() > 0) && r;
      @(posedge clk);
      #1;
      if (adv) begin
         mpos++;
         if (mpos == FFTL) begin
            mpos = 0;
            void'(mq.pop_front());
         end
      end
      if (cap) mq.push_back(f);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < int'(FFTL); i++) begin
         in_re[i*FFTW +: FFTW] = FFTW'($urandom);
         in_im[i*FFTW +: FFTW] = FFTW'($urandom);
      end
   endtask

   task automatic fill_const(input int re_v);
      for (int i = 0; i < int'(FFTL); i++) begin
         in_re[i*FFTW +: FFTW] = FFTW'(re_v);
         in_im[i*FFTW +: FFTW] = '0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
      #2;
      total++;
      if (obs !== {1'b1, {(OBSW-1){1'b0}}}) begin
         bad++; $display("FAIL reset_async got=%h want=%h", obs, {1'b1, {(OBSW-1){1'b0}}});
      end
      @(posedge clk); #1; @(posedge clk); #1;
      total++;
      if (obs !== {1'b1, {(OBSW-1){1'b0}}}) begin
         bad++; $display("FAIL reset_held got=%h want=%h", obs, {1'b1, {(OBSW-1){1'b0}}});
      end
      rst_n = 1'b1;
      mq.delete(); mpos = 0;
      step(1'b0, 1'b1);
      total++;
      if (obs !== model_out()) begin
         bad++; $display("FAIL reset_release got=%h want=%h", obs, model_out());
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < int'(FFTL); i++) begin
         in_re[i*FFTW +: FFTW] = FFTW'(i);
         in_im[i*FFTW +: FFTW] = FFTW'(-i);
      end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
      step(1'b1, 1'b1);
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", out_valid); end
      for (int k = 0; k < int'(FFTL); k++) begin
         total++;
         if (obs !== model_out()) begin
            bad++; $display("FAIL basic_model k=%0d got=%h want=%h", k, obs, model_out());
         end
         total++;
         if (out_idx !== IDXW'(map_exp(k)) || out_re !== FFTW'(map_exp(k)) ||
             out_im !== FFTW'(-map_exp(k)) || out_last !== (k == int'(FFTL) - 1)) begin
            bad++;
            $display("FAIL basic_bin k=%0d got idx=%0d re=%h im=%h last=%b want idx=%0d re=%h im=%h last=%b",
                     k, out_idx, out_re, out_im, out_last, map_exp(k), FFTW'(map_exp(k)),
                     FFTW'(-map_exp(k)), (k == int'(FFTL) - 1));
         end
         step(1'b0, 1'b1);
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_backpressure();
      int   c = 0;
      int   got = 0;
      int   last_c = -1;
      logic r;
      exp_t prev;
      fill_rand();
      step(1'b1, 1'b0);
      prev = obs;
      while (mq.size() > 0 && c < 200) begin
         r = (c % 3 == 0);
         total++;
         if (obs !== model_out()) begin
            bad++; $display("FAIL bp_model c=%0d got=%h want=%h", c, obs, model_out());
         end
         if (c > 0 && (c % 3) != 1) begin
            total++;
            if (obs !== prev) begin bad++; $display("FAIL bp_stable c=%0d got=%h want=%h", c, obs, prev); end
         end
         if (r && mq.size() > 0) begin got++; last_c = c; end
         prev = obs;
         step(1'b0, r);
         c++;
      end
      total++;
      if (got != int'(FFTL)) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got, FFTL); end
      total++;
      if (last_c + 1 != 46) begin bad++; $display("FAIL bp_cycles got=%0d want=46", last_c + 1); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_pingpong();
      fill_const(1);
      step(1'b1, 1'b0);
      fill_const(2);
      step(1'b1, 1'b0);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL pp_full got=%b want=0", in_ready); end
      fill_const(3);
      step(1'b1, 1'b0);
      total++;
      if (in_ready !== 1'b0 || out_re !== FFTW'(1)) begin
         bad++; $display("FAIL pp_reject got rdy=%b re=%h want rdy=0 re=01", in_ready, out_re);
      end
      for (int k = 0; k < 2 * int'(FFTL); k++) begin
         total++;
         if (in_ready !== (k >= int'(FFTL))) begin
            bad++; $display("FAIL pp_ready k=%0d got=%b want=%b", k, in_ready, (k >= int'(FFTL)));
         end
         total++;
         if (out_valid !== 1'b1 || out_re !== FFTW'(k < int'(FFTL) ? 1 : 2) || obs !== model_out()) begin
            bad++; $display("FAIL pp_stream k=%0d got=%h want=%h", k, obs, model_out());
         end
         step(1'b0, 1'b1);
      end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL pp_drain got=%b want=0", out_valid); end
   endtask

   task automatic test_throughput();
      int   acc = 0;
      logic v;
      for (int t = 0; t < 67; t++) begin
         v = (t % 16 == 0) && (t < 64);
         if (v) fill_rand();
         if (t >= 1 && t <= 64) begin
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL tp_gap t=%0d got=%b want=1", t, out_valid); end
         end
         if (t == 65) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL tp_drain got=%b want=0", out_valid); end
         end
         total++;
         if (obs !== model_out()) begin
            bad++; $display("FAIL tp_model t=%0d got=%h want=%h", t, obs, model_out());
         end
         if (mq.size() > 0) acc++;
         step(v, 1'b1);
      end
      total++;
      if (acc != 64) begin bad++; $display("FAIL tp_bins got=%0d want=64", acc); end
   endtask

   task automatic test_reset_mid();
      fill_rand();
      step(1'b1, 1'b1);
      fill_rand();
      step(1'b1, 1'b1);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
      total++;
      if (out_idx !== IDXW'(map_exp(6))) begin
         bad++; $display("FAIL rm_pos got=%0d want=%0d", out_idx, map_exp(6));
      end
      rst_n = 1'b0;
      #2;
      total++;
      if (out_valid !== 1'b0 || out_idx !== '0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL rm_reset got v=%b idx=%0d rdy=%b want v=0 idx=0 rdy=1", out_valid, out_idx, in_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      mq.delete(); mpos = 0;
      for (int k = 0; k < 20; k++) begin
         total++;
         if (out_valid !== 1'b0 || obs !== model_out()) begin
            bad++; $display("FAIL rm_stale k=%0d got=%h want=%h", k, obs, model_out());
         end
         step(1'b0, 1'b1);
      end
   endtask

   task automatic test_random();
      logic v;
      logic r;
      for (int ph = 0; ph < 3; ph++) begin
         for (int t = 0; t < 400; t++) begin
            v = ($urandom_range(0, 3) < ph + 1);
            r = ($urandom_range(0, 3) >= ph);
            if (v) fill_rand();
            total++;
            if (obs !== model_out()) begin
               bad++; $display("FAIL rand ph=%0d t=%0d got=%h want=%h", ph, t, obs, model_out());
            end
            step(v, r);
         end
      end
      for (int t = 0; t < 40; t++) step(1'b0, 1'b1);
      total++;
      if (obs !== model_out() || out_valid !== 1'b0) begin
         bad++; $display("FAIL rand_drain got=%h want=%h", obs, model_out());
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      mpos  = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_pingpong();
      test_throughput();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
